seven_seg_scan_ctrl: RTL and testbench



---
 rtl/seven_seg_scan_ctrl.sv | 115 +++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with frame-aligned double buffering.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module seven_seg_scan_ctrl #(
    parameter int CLK_DIV = 50000,
    parameter int GUARD   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    output logic [3:0]  bcd_out,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST    = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   shadow_val;
    logic [3:0]    shadow_dp;
    logic [15:0]   active_val;
    logic [3:0]    active_dp;
    logic          pending;

    logic          slot_end;
    logic          wrap;
    logic [3:0]    nibble;
    logic          digit_dp;
    logic          blank;
    logic          dark;
    logic [3:0]    an_next;
    logic          dp_next;

    assign slot_end = (cnt == LAST);
    assign wrap     = slot_end && (idx == 2'd3);

    // A load landing on the frame wrap bypasses the shadow so the new frame shows it at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= 2'd0;
            shadow_val <= 16'h0000;
            shadow_dp  <= 4'h0;
            active_val <= 16'h0000;
            active_dp  <= 4'h0;
            pending    <= 1'b0;
        end else begin
            cnt <= slot_end ? '0 : cnt + CW'(1);
            if (slot_end) begin
                idx <= idx + 2'd1;
            end
            if (wrap) begin
                if (load) begin
                    active_val <= value_in;
                    active_dp  <= dp_in;
                    pending    <= 1'b0;
                end else if (pending) begin
                    active_val <= shadow_val;
                    active_dp  <= shadow_dp;
                    pending    <= 1'b0;
                end
            end else if (load) begin
                shadow_val <= value_in;
                shadow_dp  <= dp_in;
                pending    <= 1'b1;
            end
        end
    end

    always_comb begin
        nibble   = 4'h0;
        digit_dp = 1'b0;
        blank    = 1'b0;
        case (idx)
            2'd0: begin nibble = active_val[3:0];   digit_dp = active_dp[0]; end
            2'd1: begin nibble = active_val[7:4];   digit_dp = active_dp[1]; end
            2'd2: begin nibble = active_val[11:8];  digit_dp = active_dp[2]; end
            default: begin nibble = active_val[15:12]; digit_dp = active_dp[3]; end
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        // A requested decimal point keeps an otherwise-blank zero digit lit.
        case (idx)
            2'd1:    blank = (active_val[15:4] == 12'h000) && !active_dp[1];
            2'd2:    blank = (active_val[15:8] == 8'h00)   && !active_dp[2];
            2'd3:    blank = (active_val[15:12] == 4'h0)   && !active_dp[3];
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif
        dark    = (cnt < GUARD_C) || blank;
        an_next = dark ? 4'b1111 : ~(4'b0001 << idx);
        dp_next = dark ? 1'b1 : ~digit_dp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an         <= 4'b1111;
            bcd_out    <= 4'h0;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_next;
            bcd_out    <= nibble;
            dp         <= dp_next;
            frame_tick <= wrap;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed self-checking bench for seven_seg_scan_ctrl with CLK_DIV=8, GUARD=2 (32-cycle frames).
module tb_seven_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic [3:0]  bcd_out;
    logic [3:0]  an;
    logic        dp;
    logic        frame_tick;

    int checks   = 0;
    int failures = 0;
    int pos      = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [3:0] ZERO_MASK = 4'b1110;
    localparam logic [3:0] MASK_0050 = 4'b0100;
`else
    localparam logic [3:0] ZERO_MASK = 4'b0000;
    localparam logic [3:0] MASK_0050 = 4'b0000;
`endif

    seven_seg_scan_ctrl #(.CLK_DIV(8), .GUARD(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .bcd_out    (bcd_out),
        .an         (an),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s pos=%0d observed=%h expected=%h", tag, pos, observed, expected);
        end
    endtask

    // Expected outputs for the scan position pos: slot c = pos%8, digit i = (pos/8)%4.
    task automatic checkExpected(input string tag, input logic [15:0] val, input logic [3:0] dpm,
                                 input logic [3:0] blank_mask);
        int         c;
        int         i;
        logic       lit;
        logic [3:0] exp_an;
        logic [3:0] exp_bcd;
        logic       exp_dp;
        logic       exp_ft;
        c       = pos % 8;
        i       = (pos / 8) % 4;
        lit     = (c >= 2) && !blank_mask[i];
        exp_an  = lit ? ~(4'b0001 << i) : 4'b1111;
        exp_bcd = val[4*i +: 4];
        exp_dp  = lit ? ~dpm[i] : 1'b1;
        exp_ft  = ((pos % 32) == 31);
        checkOutput({tag, "_an"},  an,               exp_an);
        checkOutput({tag, "_bcd"}, bcd_out,          exp_bcd);
        checkOutput({tag, "_dp"},  {3'b000, dp},     {3'b000, exp_dp});
        checkOutput({tag, "_ft"},  {3'b000, frame_tick}, {3'b000, exp_ft});
    endtask

    // Runs len cycles, optionally pulsing load at two offsets, checking every cycle.
    task automatic applyStimulus(input string tag, input int len,
                                 input logic [15:0] val, input logic [3:0] dpm, input logic [3:0] blank_mask,
                                 input int at1, input logic [15:0] v1, input logic [3:0] d1,
                                 input int at2, input logic [15:0] v2, input logic [3:0] d2);
        for (int k = 0; k < len; k++) begin
            if (k == at1) begin
                load = 1'b1; value_in = v1; dp_in = d1;
            end else if (k == at2) begin
                load = 1'b1; value_in = v2; dp_in = d2;
            end
            @(posedge clk);
            #1;
            load = 1'b0;
            checkExpected(tag, val, dpm, blank_mask);
            pos++;
        end
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        value_in = 16'h0000;
        dp_in    = 4'h0;

        for (int r = 0; r < 3; r++) begin
            @(posedge clk);
            #1;
            checkOutput("rst_an",  an,      4'b1111);
            checkOutput("rst_bcd", bcd_out, 4'h0);
            checkOutput("rst_dp",  {3'b000, dp},         4'h1);
            checkOutput("rst_ft",  {3'b000, frame_tick}, 4'h0);
        end
        rst = 1'b0;
        pos = 0;

        $display("[TB] frame 0: idle scan after reset");
        applyStimulus("f0", 32, 16'h0000, 4'h0, ZERO_MASK, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        $display("[TB] frame 1: load 1234 at digit 1, display unchanged");
        applyStimulus("f1", 32, 16'h0000, 4'h0, ZERO_MASK, 10, 16'h1234, 4'b0100, -1, 16'h0, 4'h0);

        $display("[TB] frame 2: shows 1234, two loads 1111 then 5678");
        applyStimulus("f2", 32, 16'h1234, 4'b0100, 4'h0, 3, 16'h1111, 4'h0, 20, 16'h5678, 4'h0);

        $display("[TB] frame 3: shows 5678, load 9999 on the wrap cycle");
        applyStimulus("f3", 32, 16'h5678, 4'h0, 4'h0, 31, 16'h9999, 4'h0, -1, 16'h0, 4'h0);

        $display("[TB] frame 4: forwarded 9999 shown immediately");
        applyStimulus("f4", 32, 16'h9999, 4'h0, 4'h0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        $display("[TB] frame 5: still 9999, pending 4321 then reset at digit 2 slot 5");
        applyStimulus("f5", 21, 16'h9999, 4'h0, 4'h0, 10, 16'h4321, 4'hF, -1, 16'h0, 4'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid_rst_an",  an,      4'b1111);
        checkOutput("mid_rst_bcd", bcd_out, 4'h0);
        checkOutput("mid_rst_dp",  {3'b000, dp},         4'h1);
        checkOutput("mid_rst_ft",  {3'b000, frame_tick}, 4'h0);
        rst = 1'b0;
        pos = 0;

        $display("[TB] frames 6-7: zero display, discarded pending never appears");
        applyStimulus("f6", 32, 16'h0000, 4'h0, ZERO_MASK, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        applyStimulus("f7", 32, 16'h0000, 4'h0, ZERO_MASK, 5, 16'h0050, 4'b1000, -1, 16'h0, 4'h0);

        $display("[TB] frame 8: shows 0050 with dp on digit 3");
        applyStimulus("f8", 32, 16'h0050, 4'b1000, MASK_0050, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
